// File: rtl/scene_sequencer_if.sv
// ============================================================================
//  Module      : scene_sequencer_if
//  Description : Video bus between the scene sequencer and the pixel
//                generators / VGA pins.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface scene_sequencer_if;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] splash_color;
    logic [2:0] game_color;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [2:0] rgb;
    logic       frame_tick;
    logic [1:0] scene;

    modport master (
        output x, y, hsync, vsync, video_on, rgb, frame_tick, scene,
        input  splash_color, game_color
    );

    modport slave (
        input  x, y, hsync, vsync, video_on, rgb, frame_tick, scene,
        output splash_color, game_color
    );
endinterface

`default_nettype wire

// File: rtl/scene_sequencer.sv
// ============================================================================
//  Module      : scene_sequencer
//  Description : 640x480 VGA raster timing plus frame-synchronous scene FSM
//                (SPLASH/GAME/PAUSE/OVER) selecting the registered pixel colour.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module scene_sequencer #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int SPLASH_FRAMES = 120
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               game_over,
    scene_sequencer_if.master  vid
);

    localparam int         H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS       = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS       = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END      = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_FIRST    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END      = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [7:0] SPLASH_LAST = 8'(SPLASH_FRAMES - 1);

    localparam int BTN_START = 0;
    localparam int BTN_PAUSE = 1;
    localparam int BTN_OVER  = 2;

    typedef enum logic [1:0] {
        S_SPLASH = 2'd0,
        S_GAME   = 2'd1,
        S_PAUSE  = 2'd2,
        S_OVER   = 2'd3
    } scene_t;

    // Raster counters
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       eob;

    // Scene state
    scene_t     scene_q, scene_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Button edge detection
    logic [2:0] btn_q, btn_q2;
    logic [2:0] pend_q, pend_d;
    logic [2:0] rise;
    logic [2:0] ev;

    // Registered video outputs
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic [2:0] rgb_q, rgb_d;
    logic [2:0] color;
    logic       frame_tick_q;

    assign eob  = (h_q == H_LAST) && (v_q == V_LAST);
    // Edges come from the registered copies, so an edge landing in the eob
    // cycle itself is only acted on at the following frame boundary.
    assign rise = btn_q & ~btn_q2;
    assign ev   = pend_q | rise;

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    always_comb begin
        scene_d     = scene_q;
        frame_cnt_d = frame_cnt_q;
        pend_d      = pend_q | rise;
        if (eob) begin
            pend_d = '0;
            case (scene_q)
                S_SPLASH: begin
                    if (ev[BTN_START] || (frame_cnt_q == SPLASH_LAST))
                        scene_d = S_GAME;
                end
                S_GAME: begin
                    if (ev[BTN_OVER])
                        scene_d = S_OVER;
                    else if (ev[BTN_PAUSE])
                        scene_d = S_PAUSE;
                end
                S_PAUSE: begin
                    if (ev[BTN_PAUSE])
                        scene_d = S_GAME;
                end
                S_OVER: begin
                    if (ev[BTN_START])
                        scene_d = S_SPLASH;
                end
                default: scene_d = S_SPLASH;
            endcase
            if (scene_d != scene_q)
                frame_cnt_d = '0;
            else if (frame_cnt_q != 8'hFF)
                frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_comb begin
        video_on_d = (h_q < H_VIS) && (v_q < V_VIS);
        hsync_d    = !((h_q >= HS_FIRST) && (h_q < HS_END));
        vsync_d    = !((v_q >= VS_FIRST) && (v_q < VS_END));
        color      = '0;
        case (scene_q)
            S_SPLASH: color = vid.splash_color;
            S_GAME:   color = vid.game_color;
            S_PAUSE:  color = v_q[0] ? 3'b000 : vid.game_color;
            S_OVER:   color = frame_cnt_q[4] ? vid.game_color : 3'b100;
            default:  color = '0;
        endcase
        rgb_d = video_on_d ? color : 3'b000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q          <= '0;
            v_q          <= '0;
            scene_q      <= S_SPLASH;
            frame_cnt_q  <= '0;
            btn_q        <= '0;
            btn_q2       <= '0;
            pend_q       <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            video_on_q   <= 1'b0;
            rgb_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            scene_q      <= scene_d;
            frame_cnt_q  <= frame_cnt_d;
            btn_q        <= {game_over, pause_btn, start_btn};
            btn_q2       <= btn_q;
            pend_q       <= pend_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            rgb_q        <= rgb_d;
            frame_tick_q <= eob;
        end
    end

    assign vid.x          = h_q;
    assign vid.y          = v_q;
    assign vid.hsync      = hsync_q;
    assign vid.vsync      = vsync_q;
    assign vid.video_on   = video_on_q;
    assign vid.rgb        = rgb_q;
    assign vid.frame_tick = frame_tick_q;
    assign vid.scene      = scene_q;

endmodule

`default_nettype wire

// File: tb/tb_scene_sequencer.sv
// ============================================================================
//  Module      : tb_scene_sequencer
//  Description : Scoreboard bench for scene_sequencer on a shrunken raster.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_scene_sequencer;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int SPF = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_btn = 1'b0;
    logic pause_btn = 1'b0;
    logic game_over = 1'b0;

    scene_sequencer_if vif();

    scene_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SPLASH_FRAMES(SPF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_btn (start_btn),
        .pause_btn (pause_btn),
        .game_over (game_over),
        .vid       (vif.master)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint     due;
        logic [2:0] rgb;
    } px_t;

    px_t        px_q[$];
    logic [1:0] scene_q[$];
    longint     tick_ref = 0;
    bit         tick_ok = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: scoreboard pops plus raster-timing checks
    logic       hs_prev = 1'b1, vs_prev = 1'b1, prev_valid = 1'b0;
    int         hs_run = 0, vs_run = 0;
    logic [9:0] prev_x = '0, prev_y = '0;

    always @(negedge clk) begin
        px_t        e;
        logic [1:0] s;
        if (!rst_n) begin
            hs_prev = 1'b1; vs_prev = 1'b1; prev_valid = 1'b0;
            hs_run = 0; vs_run = 0;
        end else begin
            if (px_q.size() > 0 && px_q[0].due == cyc) begin
                e = px_q.pop_front();
                chk("pixel_rgb", 32'(vif.rgb), 32'(e.rgb));
            end
            if (!vif.video_on) chk("blank_rgb", 32'(vif.rgb), 0);
            if (prev_valid) begin
                chk("video_on", 32'(vif.video_on), 32'((32'(prev_x) < HA) && (32'(prev_y) < VA)));
                if (hs_prev && !vif.hsync) chk("hsync_start_h", 32'(prev_x), HA + HF);
                if (vs_prev && !vif.vsync) chk("vsync_start_line", 32'(prev_y), VA + VF);
            end
            if (!vif.hsync) hs_run++;
            else begin
                if (!hs_prev) chk("hsync_width", hs_run, HS);
                hs_run = 0;
            end
            if (!vif.vsync) vs_run++;
            else begin
                if (!vs_prev) chk("vsync_width", vs_run, VS * HT);
                vs_run = 0;
            end
            if (vif.frame_tick) begin
                if (tick_ok) chk("tick_period", 32'(cyc - tick_ref), FRAME);
                tick_ref = cyc;
                tick_ok  = 1;
                if (scene_q.size() > 0) begin
                    s = scene_q.pop_front();
                    chk("scene_at_tick", 32'(vif.scene), 32'(s));
                end else begin
                    checks++; errors++;
                    $display("FAIL scene_at_tick: unexpected frame_tick, scene=%0d", vif.scene);
                end
            end
            hs_prev = vif.hsync; vs_prev = vif.vsync;
            prev_x = vif.x; prev_y = vif.y; prev_valid = 1'b1;
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin @(negedge clk); n++; end while (!vif.frame_tick && n < 2 * FRAME);
        if (!vif.frame_tick) begin
            checks++; errors++;
            $display("FAIL wait_tick: no frame_tick within %0d cycles", 2 * FRAME);
        end
    endtask

    task automatic goto_xy(input int tx, input int ty);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(32'(vif.x) == tx && 32'(vif.y) == ty) && n < 2 * FRAME);
        if (!(32'(vif.x) == tx && 32'(vif.y) == ty)) begin
            checks++; errors++;
            $display("FAIL goto_xy: never reached (%0d,%0d), at (%0d,%0d)", tx, ty, vif.x, vif.y);
        end
    endtask

    task automatic expect_px(input int tx, input int ty, input logic [2:0] rgb);
        goto_xy(tx, ty);
        px_q.push_back('{cyc + 1, rgb});
    endtask

    task automatic expect_scene(input logic [1:0] s);
        scene_q.push_back(s);
    endtask

    task automatic release_reset();
        @(negedge clk); #2;
        rst_n    = 1'b1;
        tick_ref = cyc;
        tick_ok  = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hsync"},    32'(vif.hsync), 1);
        chk({tag, "_vsync"},    32'(vif.vsync), 1);
        chk({tag, "_video_on"}, 32'(vif.video_on), 0);
        chk({tag, "_rgb"},      32'(vif.rgb), 0);
        chk({tag, "_tick"},     32'(vif.frame_tick), 0);
        chk({tag, "_scene"},    32'(vif.scene), 0);
        chk({tag, "_x"},        32'(vif.x), 0);
        chk({tag, "_y"},        32'(vif.y), 0);
    endtask

    initial begin
        vif.splash_color = 3'b010;
        vif.game_color   = 3'b101;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        release_reset();

        // SPLASH auto-advance after SPF frames
        expect_scene(2'd0);
        expect_px(3, 2, 3'b010);
        expect_px(9, 2, 3'b000);
        wait_tick();
        expect_scene(2'd0);
        wait_tick();
        expect_scene(2'd1);
        expect_px(7, 5, 3'b010);
        wait_tick();

        // GAME: pause and game_over together -> OVER
        expect_scene(2'd3);
        expect_px(3, 2, 3'b101);
        goto_xy(5, 3);
        pause_btn = 1'b1; game_over = 1'b1;
        goto_xy(8, 3);
        pause_btn = 1'b0; game_over = 1'b0;
        vif.game_color = 3'b011;
        wait_tick();

        // OVER blink: red for frames 0..15, game colour from 16
        for (int k = 0; k <= 16; k++) begin
            expect_scene(k == 16 ? 2'd0 : 2'd3);
            if (k == 0 || k == 15) expect_px(2, 1, 3'b100);
            if (k == 16) expect_px(2, 1, 3'b011);
            if (k == 0) begin
                goto_xy(4, 2); pause_btn = 1'b1;
                goto_xy(6, 2); pause_btn = 1'b0;
            end
            if (k == 16) begin
                goto_xy(4, 4); start_btn = 1'b1;
                goto_xy(6, 4); start_btn = 1'b0;
            end
            wait_tick();
        end

        // SPLASH: start mid-frame only takes effect at the boundary
        expect_scene(2'd1);
        expect_px(1, 1, 3'b010);
        goto_xy(5, 3);
        start_btn = 1'b1;
        goto_xy(HT - 1, VT - 1);
        chk("scene_mid_frame", 32'(vif.scene), 0);
        wait_tick();

        // GAME: pause edge -> PAUSE
        start_btn = 1'b0;
        vif.game_color = 3'b110;
        expect_scene(2'd2);
        goto_xy(2, 2); pause_btn = 1'b1;
        goto_xy(4, 2); pause_btn = 1'b0;
        wait_tick();

        // PAUSE: scanline dim; start/game_over ignored; pause -> GAME
        expect_scene(2'd1);
        expect_px(3, 0, 3'b110);
        expect_px(3, 1, 3'b000);
        expect_px(3, 2, 3'b110);
        goto_xy(2, 3); game_over = 1'b1; start_btn = 1'b1;
        goto_xy(4, 3); game_over = 1'b0; start_btn = 1'b0;
        goto_xy(2, 4); pause_btn = 1'b1;
        goto_xy(4, 4); pause_btn = 1'b0;
        wait_tick();

        // pause held for 5 frames -> single transition
        expect_scene(2'd2);
        goto_xy(2, 2); pause_btn = 1'b1;
        wait_tick();
        for (int k = 1; k <= 4; k++) begin
            expect_scene(2'd2);
            if (k == 4) begin goto_xy(2, 2); pause_btn = 1'b0; end
            wait_tick();
        end

        // Asynchronous reset mid-frame while in PAUSE, inside the sync pulses
        expect_scene(2'd2);
        goto_xy(HA + HF + 1, VA + VF);
        #2;
        rst_n = 1'b0;
        #1;
        scene_q.delete();
        px_q.delete();
        tick_ok = 0;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        release_reset();
        #1;
        chk("post_reset_x", 32'(vif.x), 0);
        chk("post_reset_y", 32'(vif.y), 0);
        chk("post_reset_scene", 32'(vif.scene), 0);
        expect_scene(2'd0);
        wait_tick();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
